// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM channel: FSM state encodings and default width.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: emits tick once every PRESCALE clocks, held at phase 0 while clr is high.
module pwm_tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  // With PRESCALE=1, LAST is 0 so r_pre never leaves 0 and tick is constantly high.
  assign tick = (r_pre == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (clr || tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered period/duty taken at period boundaries, drains the
// current period when disabled, registered pwm output lagging the counter by one clock.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH    = PWM_WIDTH_DEFAULT,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm,
  output logic             cycle_done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  pwm_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_per_sh, w_per_nxt;
  logic [WIDTH-1:0] r_duty_sh, w_duty_nxt;
  logic             r_pwm, w_pwm_nxt;
  logic             r_cycle_done, w_done_nxt;
  logic             w_tick;
  logic             w_clr;
  logic             w_term;

  assign w_clr = (r_state == ST_IDLE);

  pwm_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  // A zero period is terminal on every tick, so the counter never leaves 0.
  assign w_term = w_tick && ((r_per_sh == '0) || (r_cnt == r_per_sh - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_per_sh     <= '0;
      r_duty_sh    <= '0;
      r_pwm        <= 1'b0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_per_sh     <= w_per_nxt;
      r_duty_sh    <= w_duty_nxt;
      r_pwm        <= w_pwm_nxt;
      r_cycle_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_per_nxt   = r_per_sh;
    w_duty_nxt  = r_duty_sh;
    w_done_nxt  = 1'b0;
    w_pwm_nxt   = (r_state != ST_IDLE) && (r_per_sh != '0) && (r_cnt < r_duty_sh);

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (en) begin
          w_per_nxt   = period;
          w_duty_nxt  = duty;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        // RUN and DRAIN count identically; en only decides what happens at the boundary.
        w_state_nxt = en ? ST_RUN : ST_DRAIN;
        if (w_term) begin
          w_cnt_nxt  = '0;
          w_done_nxt = 1'b1;
          if (en) begin
            w_per_nxt  = period;
            w_duty_nxt = duty;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_tick) begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign pwm        = r_pwm;
  assign cycle_done = r_cycle_done;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pwm_channel.sv
// Bench for pwm_channel: per-period scoreboard of (high clocks, period clocks) on a
// PRESCALE=1 channel and a PRESCALE=4 channel, plus direct checks of reset/latency/idle.
module tb_pwm_channel;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en0 = 1'b0, en1 = 1'b0;
  logic [W-1:0] period0 = '0, duty0 = '0, period1 = '0, duty1 = '0;
  logic         pwm0, done0, busy0, pwm1, done1, busy1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int ch;
    int hi;
    int len;
  } exp_t;

  exp_t sb[$];
  int   acc_hi[2];
  int   acc_len[2];
  logic prev_busy[2];

  always #5 clk = ~clk;

  pwm_channel #(.WIDTH(W), .PRESCALE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en0),
    .period     (period0),
    .duty       (duty0),
    .pwm        (pwm0),
    .cycle_done (done0),
    .busy       (busy0)
  );

  pwm_channel #(.WIDTH(W), .PRESCALE(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .en         (en1),
    .period     (period1),
    .duty       (duty1),
    .pwm        (pwm1),
    .cycle_done (done1),
    .busy       (busy1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int hi, input int len, input int n);
    exp_t e;
    e.ch  = ch;
    e.hi  = hi;
    e.len = len;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge on which the channel's cycle_done rises.
  task automatic wait_boundary(input int ch);
    int   n;
    logic d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      d = (ch == 0) ? done0 : done1;
    end while (!d && n < 200);
    if (!d) check("boundary_timeout", int'(d), 1);
  endtask

  // Period monitor: a sample belongs to a period if the channel was busy on the
  // previous sample (pwm lags state by one clock); cycle_done marks the last sample.
  always @(negedge clk) begin
    logic [1:0] pv, dv, bv;
    exp_t e;
    pv = {pwm1, pwm0};
    dv = {done1, done0};
    bv = {busy1, busy0};
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        acc_hi[c]    = 0;
        acc_len[c]   = 0;
        prev_busy[c] = 1'b0;
      end else begin
        if (prev_busy[c]) begin
          acc_len[c]++;
          if (pv[c]) acc_hi[c]++;
        end
        if (dv[c]) begin
          if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("period_ch", c, e.ch);
            check("period_hi", acc_hi[c], e.hi);
            check("period_len", acc_len[c], e.len);
          end
          acc_hi[c]  = 0;
          acc_len[c] = 0;
        end
        prev_busy[c] = bv[c];
      end
    end
  end

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_pwm", int'(pwm0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);

    // 10/3 basic operation and first-edge latency
    @(posedge clk);
    #1;
    rst     = 1'b0;
    period0 = 10;
    duty0   = 3;
    push_exp(0, 3, 10, 3);
    en0 = 1'b1;
    step(1);
    check("lat_busy", int'(busy0), 1);
    check("lat_pwm_first", int'(pwm0), 0);
    step(1);
    check("lat_pwm_second", int'(pwm0), 1);
    wait_boundary(0);
    wait_boundary(0);
    wait_boundary(0);

    // Duty written mid-period only takes effect at the next boundary
    push_exp(0, 3, 10, 1);
    push_exp(0, 7, 10, 1);
    step(4);
    duty0 = 7;
    wait_boundary(0);
    wait_boundary(0);

    // 0% and 100% duty
    push_exp(0, 7, 10, 1);
    duty0 = 0;
    wait_boundary(0);
    push_exp(0, 0, 10, 1);
    duty0 = 12;
    wait_boundary(0);
    push_exp(0, 10, 10, 2);
    wait_boundary(0);

    // en drop at cnt=2, re-raise at cnt=5: no gap, no truncation
    step(2);
    en0   = 1'b0;
    duty0 = 3;
    step(3);
    check("drain_busy", int'(busy0), 1);
    en0 = 1'b1;
    wait_boundary(0);
    // en drop with no re-raise: period completes then IDLE
    push_exp(0, 3, 10, 1);
    step(2);
    en0 = 1'b0;
    wait_boundary(0);
    check("idle_busy", int'(busy0), 0);
    step(3);
    check("idle_pwm", int'(pwm0), 0);
    check("idle_busy_later", int'(busy0), 0);
    check("idle_done", int'(done0), 0);

    // PRESCALE=4: 5/2 -> 8 high of 20, drained second period
    push_exp(1, 8, 20, 2);
    period1 = 5;
    duty1   = 2;
    en1     = 1'b1;
    wait_boundary(1);
    en1 = 1'b0;
    wait_boundary(1);
    check("ps4_idle_busy", int'(busy1), 0);

    // Reset mid-period while pwm is high, then restart from cnt=0
    duty0 = 8;
    en0   = 1'b1;
    step(7);
    check("pre_rst_pwm", int'(pwm0), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_pwm", int'(pwm0), 0);
    check("mid_rst_busy", int'(busy0), 0);
    check("mid_rst_done", int'(done0), 0);
    push_exp(0, 8, 10, 2);
    step(2);
    rst = 1'b0;
    step(1);
    check("restart_busy", int'(busy0), 1);
    step(1);
    check("restart_pwm", int'(pwm0), 1);
    wait_boundary(0);
    en0 = 1'b0;
    wait_boundary(0);

    step(2);
    check("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
